// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the fetch/decode stage: FSM encoding, opcode values
// and the bit positions of every field carved out of the 16-bit instruction word.
package instr_fetch_decode_pkg;

    localparam int INSTR_W = 16;
    localparam int REG_W   = 4;
    localparam int IMM_W   = 8;

    localparam int OPC_LSB       = 12;
    localparam int WR_LSB        = 8;
    localparam int RR1_LSB       = 4;
    localparam int RR2_LSB       = 0;
    localparam int OFFSET_SEL_LSB = 8;
    localparam int SWLW_SEL_LSB   = 10;

    // Offset and load/store register addresses live in fixed register-file banks.
    localparam logic [1:0] OFFSET_BANK = 2'b11;
    localparam logic [1:0] SWLW_BANK   = 2'b10;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hC;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECODE = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FAULT  = 3'd4
    } fd_state_e;

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Bundle of instruction-memory, redirect and decoded-output signals between the
// fetch/decode stage (master) and its surroundings (slave).
interface instr_fetch_decode_if #(
    parameter int ADDR_W = 16
);
    logic [15:0]       I_Mem_Rdata;
    logic              I_Mem_Valid;
    logic              I_Mem_Req;
    logic [ADDR_W-1:0] I_Mem_Addr;
    logic              C_Redirect;
    logic [ADDR_W-1:0] D_Target;
    logic              O_Ready;
    logic              O_Valid;
    logic [15:0]       D_IR;
    logic [ADDR_W-1:0] D_PC;
    logic [3:0]        D_Opcode;
    logic [15:0]       D_Imm;
    logic [3:0]        A_ReadReg1RT;
    logic [3:0]        A_ReadReg2RT;
    logic [3:0]        A_WriteRegRT_BT;
    logic [3:0]        A_Offset;
    logic [3:0]        A_RegSWLW;
    logic              O_Fault;

    modport master (
        input  I_Mem_Rdata, I_Mem_Valid, C_Redirect, D_Target, O_Ready,
        output I_Mem_Req, I_Mem_Addr, O_Valid, D_IR, D_PC, D_Opcode, D_Imm,
               A_ReadReg1RT, A_ReadReg2RT, A_WriteRegRT_BT, A_Offset, A_RegSWLW,
               O_Fault
    );

    modport slave (
        output I_Mem_Rdata, I_Mem_Valid, C_Redirect, D_Target, O_Ready,
        input  I_Mem_Req, I_Mem_Addr, O_Valid, D_IR, D_PC, D_Opcode, D_Imm,
               A_ReadReg1RT, A_ReadReg2RT, A_WriteRegRT_BT, A_Offset, A_RegSWLW,
               O_Fault
    );
endinterface

// File: rtl/instr_fetch_decode_field.sv
// Combinational field extraction from the instruction register: opcode,
// sign-extended 8-bit immediate and the five register-file addresses.
module instr_field_decode
    import instr_fetch_decode_pkg::*;
(
    input  logic [INSTR_W-1:0] ir_i,
    output logic [3:0]         opcode_o,
    output logic [INSTR_W-1:0] imm_o,
    output logic [REG_W-1:0]   read_reg1_o,
    output logic [REG_W-1:0]   read_reg2_o,
    output logic [REG_W-1:0]   write_reg_o,
    output logic [REG_W-1:0]   offset_reg_o,
    output logic [REG_W-1:0]   swlw_reg_o
);

    assign opcode_o     = ir_i[OPC_LSB +: 4];
    assign read_reg1_o  = ir_i[RR1_LSB +: REG_W];
    assign read_reg2_o  = ir_i[RR2_LSB +: REG_W];
    assign write_reg_o  = ir_i[WR_LSB +: REG_W];
    assign offset_reg_o = {OFFSET_BANK, ir_i[OFFSET_SEL_LSB +: 2]};
    assign swlw_reg_o   = {SWLW_BANK, ir_i[SWLW_SEL_LSB +: 2]};

    assign imm_o[IMM_W-1:0] = ir_i[IMM_W-1:0];

    genvar gi;
    generate
        for (gi = IMM_W; gi < INSTR_W; gi++) begin : g_sext
            assign imm_o[gi] = ir_i[IMM_W-1];
        end
    endgenerate

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode stage: PC, memory request FSM with redirect and watchdog,
// instruction register, and decoded fields presented with a valid/ready handshake.
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_decode_if.master bus
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_STEP_V  = ADDR_W'(PC_STEP);
    localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(MAX_WAIT - 1);

    fd_state_e           state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   dpc_q, dpc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [WCNT_W-1:0]   wait_q, wait_d;
    logic [WCNT_W-1:0]   wait_inc;
    logic                wait_expired;

    logic [3:0]          dec_opcode;
    logic [INSTR_W-1:0]  dec_imm;
    logic [REG_W-1:0]    dec_rr1, dec_rr2, dec_wr, dec_offset, dec_swlw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC_V;
            dpc_q   <= '0;
            ir_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            dpc_q   <= dpc_d;
            ir_q    <= ir_d;
            wait_q  <= wait_d;
        end
    end

    // Saturate so a long redirect chain in DRAIN cannot wrap the watchdog.
    assign wait_inc     = (wait_q == '1) ? wait_q : wait_q + 1'b1;
    assign wait_expired = (wait_q >= WAIT_LAST);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        dpc_d   = dpc_q;
        ir_d    = ir_q;
        wait_d  = wait_q;
        case (state_q)
            ST_FETCH: begin
                wait_d  = '0;
                state_d = ST_WAIT;
                if (bus.C_Redirect) begin
                    pc_d    = bus.D_Target;
                    state_d = ST_FETCH;
                end
            end
            ST_WAIT: begin
                wait_d = wait_inc;
                if (bus.C_Redirect) begin
                    pc_d    = bus.D_Target;
                    state_d = bus.I_Mem_Valid ? ST_FETCH : ST_DRAIN;
                end else if (bus.I_Mem_Valid) begin
                    ir_d    = bus.I_Mem_Rdata;
                    dpc_d   = pc_q;
                    pc_d    = pc_q + PC_STEP_V;
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DRAIN: begin
                // The owed response is swallowed; IR keeps the last decoded word.
                wait_d = wait_inc;
                if (bus.C_Redirect) begin
                    pc_d = bus.D_Target;
                end
                if (bus.I_Mem_Valid) begin
                    state_d = ST_FETCH;
                end else if (wait_expired && !bus.C_Redirect) begin
                    state_d = ST_FAULT;
                end
            end
            ST_DECODE: begin
                if (bus.C_Redirect) begin
                    pc_d    = bus.D_Target;
                    state_d = ST_FETCH;
                end else if (bus.O_Ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    instr_field_decode u_field_decode (
        .ir_i         (ir_q),
        .opcode_o     (dec_opcode),
        .imm_o        (dec_imm),
        .read_reg1_o  (dec_rr1),
        .read_reg2_o  (dec_rr2),
        .write_reg_o  (dec_wr),
        .offset_reg_o (dec_offset),
        .swlw_reg_o   (dec_swlw)
    );

    always_comb begin
        bus.I_Mem_Req       = !rst && ((state_q == ST_FETCH) || (state_q == ST_WAIT));
        bus.I_Mem_Addr      = pc_q;
        bus.O_Valid         = (state_q == ST_DECODE);
        bus.O_Fault         = (state_q == ST_FAULT);
        bus.D_IR            = ir_q;
        bus.D_PC            = dpc_q;
        bus.D_Opcode        = dec_opcode;
        bus.D_Imm           = dec_imm;
        bus.A_ReadReg1RT    = dec_rr1;
        bus.A_ReadReg2RT    = dec_rr2;
        bus.A_WriteRegRT_BT = dec_wr;
        bus.A_Offset        = dec_offset;
        bus.A_RegSWLW       = dec_swlw;
    end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed-plus-random bench for instr_fetch_decode; a reference model tracks PC,
// IR and D_PC and computes the decoded fields arithmetically from the word.
module tb_instr_fetch_decode;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_decode_if #(.ADDR_W(16)) bus ();

    instr_fetch_decode #(
        .ADDR_W   (16),
        .RESET_PC (0),
        .PC_STEP  (1),
        .MAX_WAIT (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] m_pc, m_ir, m_dpc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fields(input logic [15:0] w);
        int u, lo;
        u  = int'(w);
        lo = u % 256;
        chk("opcode", {28'd0, bus.D_Opcode},        u / 4096);
        chk("rr1",    {28'd0, bus.A_ReadReg1RT},    (u / 16) % 16);
        chk("rr2",    {28'd0, bus.A_ReadReg2RT},    u % 16);
        chk("wr",     {28'd0, bus.A_WriteRegRT_BT}, (u / 256) % 16);
        chk("offset", {28'd0, bus.A_Offset},        12 + (u / 256) % 4);
        chk("swlw",   {28'd0, bus.A_RegSWLW},       8 + (u / 1024) % 4);
        chk("imm",    {16'd0, bus.D_Imm},           (lo < 128) ? lo : lo + 65280);
    endtask

    // One complete fetch: FETCH, lat silent WAIT cycles, response, then DECODE
    // held for hold extra cycles; optional redirect on the accepting DECODE cycle.
    task automatic run_fetch(input logic [15:0] word, input int lat, input int hold,
                             input bit redir, input logic [15:0] tgt);
        @(negedge clk);
        bus.O_Ready    = 1'b0;
        bus.C_Redirect = 1'b0;
        chk("fetch_req",   {31'd0, bus.I_Mem_Req}, 1);
        chk("fetch_addr",  {16'd0, bus.I_Mem_Addr}, {16'd0, m_pc});
        chk("fetch_ovld",  {31'd0, bus.O_Valid}, 0);
        chk("fetch_ir",    {16'd0, bus.D_IR}, {16'd0, m_ir});
        bus.I_Mem_Valid = 1'b0;
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            chk("wait_req",  {31'd0, bus.I_Mem_Req}, 1);
            chk("wait_ovld", {31'd0, bus.O_Valid}, 0);
            bus.I_Mem_Valid = (i == lat);
            bus.I_Mem_Rdata = (i == lat) ? word : 16'($urandom);
        end
        @(negedge clk);
        bus.I_Mem_Valid = 1'b0;
        m_ir  = word;
        m_dpc = m_pc;
        m_pc  = m_pc + 16'd1;
        $display("txn pc=%h word=%h lat=%0d hold=%0d redir=%0d", m_dpc, word, lat, hold, redir);
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            chk("dec_ovld", {31'd0, bus.O_Valid}, 1);
            chk("dec_req",  {31'd0, bus.I_Mem_Req}, 0);
            chk("dec_ir",   {16'd0, bus.D_IR}, {16'd0, m_ir});
            chk("dec_pc",   {16'd0, bus.D_PC}, {16'd0, m_dpc});
            if (h == 0) check_fields(m_ir);
            bus.I_Mem_Valid = 1'($urandom_range(0, 1));
            bus.I_Mem_Rdata = 16'($urandom);
            bus.O_Ready     = (h == hold);
        end
        if (redir) begin
            bus.C_Redirect = 1'b1;
            bus.D_Target   = tgt;
            m_pc           = tgt;
        end
    endtask

    // Redirect on the first WAIT cycle; the owed response arrives gap cycles later.
    task automatic redirect_in_wait(input logic [15:0] tgt, input int gap, input logic [15:0] junk);
        @(negedge clk);
        bus.O_Ready    = 1'b0;
        bus.C_Redirect = 1'b0;
        chk("rw_fetch_addr", {16'd0, bus.I_Mem_Addr}, {16'd0, m_pc});
        bus.I_Mem_Valid = 1'b0;
        @(negedge clk);
        chk("rw_wait_req", {31'd0, bus.I_Mem_Req}, 1);
        bus.C_Redirect  = 1'b1;
        bus.D_Target    = tgt;
        bus.I_Mem_Valid = (gap == 0);
        bus.I_Mem_Rdata = junk;
        m_pc = tgt;
        $display("txn redirect-in-wait target=%h gap=%0d junk=%h", tgt, gap, junk);
        for (int g = 1; g <= gap; g++) begin
            @(negedge clk);
            bus.C_Redirect = 1'b0;
            chk("rw_drain_ovld", {31'd0, bus.O_Valid}, 0);
            chk("rw_drain_ir",   {16'd0, bus.D_IR}, {16'd0, m_ir});
            bus.I_Mem_Valid = (g == gap);
            bus.I_Mem_Rdata = junk;
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.I_Mem_Rdata = '0;
        bus.I_Mem_Valid = 1'b0;
        bus.C_Redirect  = 1'b0;
        bus.D_Target    = '0;
        bus.O_Ready     = 1'b0;
        m_pc = 16'd0; m_ir = 16'd0; m_dpc = 16'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_req",   {31'd0, bus.I_Mem_Req}, 0);
        chk("rst_ovld",  {31'd0, bus.O_Valid}, 0);
        chk("rst_fault", {31'd0, bus.O_Fault}, 0);
        chk("rst_ir",    {16'd0, bus.D_IR}, 0);
        chk("rst_dpc",   {16'd0, bus.D_PC}, 0);
        check_fields(16'h0000);
        rst = 1'b0;

        // Zero-wait fetch, then a stalled consumer with a negative immediate
        run_fetch(16'h3A5C, 0, 0, 1'b0, 16'h0);
        run_fetch(16'h80F0, 1, 5, 1'b0, 16'h0);

        // Redirect during WAIT with a late response, then with a same-cycle response
        redirect_in_wait(16'h0040, 2, 16'hBEEF);
        run_fetch(16'h1234, 1, 0, 1'b0, 16'h0);
        redirect_in_wait(16'h0777, 0, 16'hDEAD);
        run_fetch(16'hC3F7, 3, 1, 1'b1, 16'hFFFF);

        // PC wrap from 0xFFFF
        run_fetch(16'h4E81, 2, 1, 1'b0, 16'h0);
        run_fetch(16'h9F7F, 0, 0, 1'b0, 16'h0);

        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 5) == 0)
                redirect_in_wait(16'($urandom), $urandom_range(0, 3), 16'($urandom));
            run_fetch(16'($urandom), $urandom_range(0, 6), $urandom_range(0, 3),
                      ($urandom_range(0, 4) == 0), 16'($urandom));
        end

        // Memory never answers: watchdog fault is sticky until reset
        @(negedge clk);
        bus.O_Ready     = 1'b0;
        bus.C_Redirect  = 1'b0;
        bus.I_Mem_Valid = 1'b0;
        chk("wd_fetch_req", {31'd0, bus.I_Mem_Req}, 1);
        $display("txn watchdog silent memory at pc=%h", m_pc);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i < 14) begin
                chk("wd_wait_req",   {31'd0, bus.I_Mem_Req}, 1);
                chk("wd_wait_fault", {31'd0, bus.O_Fault}, 0);
            end
        end
        chk("wd_fault", {31'd0, bus.O_Fault}, 1);
        chk("wd_req",   {31'd0, bus.I_Mem_Req}, 0);
        chk("wd_ovld",  {31'd0, bus.O_Valid}, 0);
        for (int i = 0; i < 3; i++) begin
            bus.C_Redirect  = 1'b1;
            bus.D_Target    = 16'h0100;
            bus.I_Mem_Valid = 1'b1;
            bus.I_Mem_Rdata = 16'h5555;
            @(negedge clk);
            chk("wd_sticky_fault", {31'd0, bus.O_Fault}, 1);
            chk("wd_sticky_req",   {31'd0, bus.I_Mem_Req}, 0);
            chk("wd_sticky_ir",    {16'd0, bus.D_IR}, {16'd0, m_ir});
        end
        rst             = 1'b1;
        bus.C_Redirect  = 1'b0;
        bus.I_Mem_Valid = 1'b0;
        @(negedge clk);
        chk("wd_rst_fault", {31'd0, bus.O_Fault}, 0);
        chk("wd_rst_req",   {31'd0, bus.I_Mem_Req}, 0);
        chk("wd_rst_ir",    {16'd0, bus.D_IR}, 0);
        chk("wd_rst_dpc",   {16'd0, bus.D_PC}, 0);
        rst  = 1'b0;
        m_pc = 16'd0; m_ir = 16'd0; m_dpc = 16'd0;
        run_fetch(16'h6A21, 1, 0, 1'b0, 16'h0);
        run_fetch(16'h0F80, 0, 2, 1'b0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
